// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a word-addressed request/ready data port.
// Optional macro MISALIGN_TRAP_EN: reject misaligned halfword/word accesses instead of masking them.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] Write_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        store_done,
  output logic        bus_error,
  output logic        misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  // Memory handshake: mem_req rises in the first BUSY cycle and stays high with
  // stable mem_we/mem_addr/mem_wdata/mem_wstrb until the cycle mem_ready is seen
  // (or the timeout expires); mem_ready is a single-cycle completion that is
  // only honoured while BUSY.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 is_store_q;
  logic [2:0]           f3_q;
  logic [1:0]           lane_q;

  logic        op;
  logic        is_store;
  logic        legal;
  logic        size_half;
  logic        size_word;
  logic [1:0]  lane;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_shaped;

  // Request decode; the lane masks the low address bits a halfword/word ignores.
  always_comb begin
    op        = MemRead | MemWrite;
    is_store  = MemWrite;
    size_half = (funct3[1:0] == 2'b01);
    size_word = (funct3[1:0] == 2'b10);
    if (is_store) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    end
    lane = address[1:0];
    if (size_half) begin
      lane = {address[1], 1'b0};
    end else if (size_word) begin
      lane = 2'b00;
    end
    st_wdata = Write_data;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{Write_data[7:0]}};
        st_wstrb = 4'b0001 << lane;
      end
      2'b01: begin
        st_wdata = {2{Write_data[15:0]}};
        st_wstrb = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = Write_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misal;
  logic misal_pulse;

  always_comb begin
    misal = (size_half && address[0]) || (size_word && (address[1:0] != 2'b00));
  end

  assign misaligned = misal_pulse;
`else
  assign misaligned = 1'b0;
`endif

  // Lane select and extension of the returned word for the captured access.
  always_comb begin
    rd_byte = mem_rdata[{lane_q, 3'b000} +: 8];
    rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  rd_shaped = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_shaped = {{16{rd_half[15]}}, rd_half};
      3'b100:  rd_shaped = {24'd0, rd_byte};
      3'b101:  rd_shaped = {16'd0, rd_half};
      default: rd_shaped = mem_rdata;
    endcase
  end

  assign stall = (state == BUSY) || ((state == IDLE) && op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      is_store_q <= 1'b0;
      f3_q       <= 3'b000;
      lane_q     <= 2'b00;
      load_data  <= 32'd0;
      load_valid <= 1'b0;
      store_done <= 1'b0;
      bus_error  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'b0000;
`ifdef MISALIGN_TRAP_EN
      misal_pulse <= 1'b0;
`endif
    end else begin
      load_valid <= 1'b0;
      store_done <= 1'b0;
      bus_error  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misal_pulse <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (op) begin
            is_store_q <= is_store;
            f3_q       <= funct3;
            lane_q     <= lane;
            if (!legal) begin
              state     <= RESP;
              bus_error <= 1'b1;
            end
`ifdef MISALIGN_TRAP_EN
            else if (misal) begin
              state       <= RESP;
              misal_pulse <= 1'b1;
            end
`endif
            else begin
              state     <= BUSY;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {address[31:2], 2'b00};
              mem_wdata <= is_store ? st_wdata : 32'd0;
              mem_wstrb <= is_store ? st_wstrb : 4'b0000;
            end
          end
        end
        BUSY: begin
          if (mem_ready || (cnt == CNT_LAST)) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'b0000;
          end
          // A response arriving in the final timeout cycle still counts.
          if (mem_ready) begin
            if (is_store_q) begin
              store_done <= 1'b1;
            end else begin
              load_valid <= 1'b1;
              load_data  <= rd_shaped;
            end
          end else if (cnt == CNT_LAST) begin
            bus_error <= 1'b1;
            load_data <= 32'd0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed loads, stores, rejects, timeout and reset abort.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] Write_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        store_done;
  logic        bus_error;
  logic        misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int errors;
  int checks;
  logic [31:0] held_ld;

  mem_access_unit #(
    .TIMEOUT_CYCLES(16),
    .CNT_WIDTH(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .funct3(funct3),
    .address(address),
    .Write_data(Write_data),
    .stall(stall),
    .load_data(load_data),
    .load_valid(load_valid),
    .store_done(store_done),
    .bus_error(bus_error),
    .misaligned(misaligned),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pulses();
    return {28'd0, load_valid, store_done, bus_error, misaligned};
  endfunction

  task automatic drop_and_check_idle(input string tag);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    #1;
    chk({tag, ".idle_stall"}, stall, 0);
    chk({tag, ".idle_req"}, mem_req, 0);
    chk({tag, ".idle_pulses"}, pulses(), 0);
  endtask

  // Full access with mem_ready in the first BUSY cycle; request held through RESP.
  // Pulse order: {load_valid, store_done, bus_error, misaligned}.
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_wstrb, input logic [3:0] exp_pulse,
                        input logic [31:0] exp_ld);
    MemRead = rd; MemWrite = wr; funct3 = f3; address = addr; Write_data = wd;
    #1;
    chk({tag, ".c1_stall"}, stall, 1);
    chk({tag, ".c1_req"}, mem_req, 0);
    step();
    chk({tag, ".c2_req"}, mem_req, 1);
    chk({tag, ".c2_stall"}, stall, 1);
    chk({tag, ".c2_we"}, mem_we, wr);
    chk({tag, ".c2_addr"}, mem_addr, exp_addr);
    chk({tag, ".c2_wstrb"}, mem_wstrb, exp_wstrb);
    if (wr) chk({tag, ".c2_wdata"}, mem_wdata, exp_wdata);
    mem_ready = 1'b1; mem_rdata = rdata;
    step();
    mem_ready = 1'b0; mem_rdata = 32'd0;
    chk({tag, ".c3_stall"}, stall, 0);
    chk({tag, ".c3_req"}, mem_req, 0);
    chk({tag, ".c3_pulses"}, pulses(), exp_pulse);
    chk({tag, ".c3_ld"}, load_data, exp_ld);
    step();
    drop_and_check_idle(tag);
  endtask

  // Request answered without a memory access (illegal funct3 or trapped misalignment).
  task automatic reject(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [3:0] exp_pulse,
                        input logic [31:0] exp_ld);
    MemRead = rd; MemWrite = wr; funct3 = f3; address = addr; Write_data = 32'h5555_AAAA;
    #1;
    chk({tag, ".c1_stall"}, stall, 1);
    step();
    chk({tag, ".c2_req"}, mem_req, 0);
    chk({tag, ".c2_stall"}, stall, 0);
    chk({tag, ".c2_pulses"}, pulses(), exp_pulse);
    chk({tag, ".c2_ld"}, load_data, exp_ld);
    step();
    drop_and_check_idle(tag);
  endtask

  // Issue LW and advance to BUSY cycle 16.
  task automatic lw_to_busy16(input string tag, input logic [31:0] addr);
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; address = addr; Write_data = 32'd0;
    step();
    chk({tag, ".busy1_req"}, mem_req, 1);
    for (int i = 1; i < 16; i++) step();
    chk({tag, ".busy16_req"}, mem_req, 1);
    chk({tag, ".busy16_pulses"}, pulses(), 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000; address = 32'd0; Write_data = 32'd0;
    mem_rdata = 32'd0; mem_ready = 1'b0;

    step();
    chk("rst.stall", stall, 0);
    chk("rst.load_data", load_data, 0);
    chk("rst.pulses", pulses(), 0);
    chk("rst.req", mem_req, 0);
    chk("rst.we", mem_we, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.wdata", mem_wdata, 0);
    chk("rst.wstrb", mem_wstrb, 0);
    step();
    reset = 1'b0;

    access("sw",   0, 1, 3'b010, 32'h14, 32'hABCD1234, 32'h0,
           32'h14, 32'hABCD1234, 4'b1111, 4'b0100, 32'h0);
    access("lb15", 1, 0, 3'b000, 32'h15, 32'h0, 32'hABCD1234,
           32'h14, 32'h0, 4'b0000, 4'b1000, 32'h0000_0012);
    access("lbu17", 1, 0, 3'b100, 32'h17, 32'h0, 32'hABCD1234,
           32'h14, 32'h0, 4'b0000, 4'b1000, 32'h0000_00AB);
    access("lb17", 1, 0, 3'b000, 32'h17, 32'h0, 32'hABCD1234,
           32'h14, 32'h0, 4'b0000, 4'b1000, 32'hFFFF_FFAB);
    access("lh16", 1, 0, 3'b001, 32'h16, 32'h0, 32'hABCD1234,
           32'h14, 32'h0, 4'b0000, 4'b1000, 32'hFFFF_ABCD);
    access("lhu16", 1, 0, 3'b101, 32'h16, 32'h0, 32'hABCD1234,
           32'h14, 32'h0, 4'b0000, 4'b1000, 32'h0000_ABCD);
    access("lh14", 1, 0, 3'b001, 32'h14, 32'h0, 32'h0001_7FFF,
           32'h14, 32'h0, 4'b0000, 4'b1000, 32'h0000_7FFF);
    access("lw18", 1, 0, 3'b010, 32'h18, 32'h0, 32'h5A5A_A5A5,
           32'h18, 32'h0, 4'b0000, 4'b1000, 32'h5A5A_A5A5);
    access("sb22", 0, 1, 3'b000, 32'h22, 32'h0000_00EE, 32'h0,
           32'h20, 32'hEEEE_EEEE, 4'b0100, 4'b0100, 32'h5A5A_A5A5);
    access("sh22", 0, 1, 3'b001, 32'h22, 32'h0000_BEEF, 32'h0,
           32'h20, 32'hBEEF_BEEF, 4'b1100, 4'b0100, 32'h5A5A_A5A5);
    access("sb21", 0, 1, 3'b000, 32'h21, 32'h1234_5678, 32'h0,
           32'h20, 32'h7878_7878, 4'b0010, 4'b0100, 32'h5A5A_A5A5);
    access("sh20", 0, 1, 3'b001, 32'h20, 32'hCAFE_1234, 32'h0,
           32'h20, 32'h1234_1234, 4'b0011, 4'b0100, 32'h5A5A_A5A5);
    access("both", 1, 1, 3'b010, 32'h30, 32'h1122_3344, 32'h9999_9999,
           32'h30, 32'h1122_3344, 4'b1111, 4'b0100, 32'h5A5A_A5A5);

`ifdef MISALIGN_TRAP_EN
    reject("mis_lw13", 1, 0, 3'b010, 32'h13, 4'b0001, 32'h5A5A_A5A5);
    reject("mis_sh23", 0, 1, 3'b001, 32'h23, 4'b0001, 32'h5A5A_A5A5);
    held_ld = 32'h5A5A_A5A5;
`else
    access("lw13", 1, 0, 3'b010, 32'h13, 32'h0, 32'hDEAD_BEEF,
           32'h10, 32'h0, 4'b0000, 4'b1000, 32'hDEAD_BEEF);
    access("lh17", 1, 0, 3'b001, 32'h17, 32'h0, 32'h8000_1234,
           32'h14, 32'h0, 4'b0000, 4'b1000, 32'hFFFF_8000);
    access("sh23", 0, 1, 3'b001, 32'h23, 32'h0000_BEEF, 32'h0,
           32'h20, 32'hBEEF_BEEF, 4'b1100, 4'b0100, 32'hFFFF_8000);
    held_ld = 32'hFFFF_8000;
`endif

    reject("ill_ld011", 1, 0, 3'b011, 32'h40, 4'b0010, held_ld);
    reject("ill_st100", 0, 1, 3'b100, 32'h40, 4'b0010, held_ld);

    // mem_ready in the last allowed BUSY cycle beats the timeout
    lw_to_busy16("late", 32'h44);
    mem_ready = 1'b1; mem_rdata = 32'h1357_9BDF;
    step();
    mem_ready = 1'b0; mem_rdata = 32'd0;
    chk("late.resp_pulses", pulses(), 4'b1000);
    chk("late.resp_ld", load_data, 32'h1357_9BDF);
    step();
    drop_and_check_idle("late");

    // Reset in BUSY cycle 3 aborts with no completion
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; address = 32'h50;
    step();
    step();
    step();
    chk("abort.busy3_req", mem_req, 1);
    reset = 1'b1; MemRead = 1'b0;
    step();
    chk("abort.req", mem_req, 0);
    chk("abort.stall", stall, 0);
    chk("abort.pulses", pulses(), 0);
    chk("abort.ld", load_data, 0);
    reset = 1'b0;
    step();
    chk("abort.after_req", mem_req, 0);
    chk("abort.after_pulses", pulses(), 0);

    access("lw5c", 1, 0, 3'b010, 32'h5C, 32'h0, 32'h0F0F_0F0F,
           32'h5C, 32'h0, 4'b0000, 4'b1000, 32'h0F0F_0F0F);

    // Timeout: no mem_ready for 16 BUSY cycles
    lw_to_busy16("tmo", 32'h48);
    step();
    chk("tmo.resp_pulses", pulses(), 4'b0010);
    chk("tmo.resp_ld", load_data, 32'h0);
    chk("tmo.resp_req", mem_req, 0);
    chk("tmo.resp_stall", stall, 0);
    step();
    drop_and_check_idle("tmo");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
